// File: rtl/bms_pkg.sv
// Shared BMS definitions: sampler FSM encoding, cell/channel numbering and ADC width.
package bms_pkg;

  localparam int NUM_CELLS = 3;
  localparam int ADC_W     = 12;
  localparam int CH_W      = 2;

  localparam logic [CH_W-1:0] CH_CELL1 = 2'd0;
  localparam logic [CH_W-1:0] CH_CELL2 = 2'd1;
  localparam logic [CH_W-1:0] CH_CELL3 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_START       = 3'd1,
    ST_CONVERT     = 3'd2,
    ST_PUBLISH     = 3'd3,
    ST_WAIT_PERIOD = 3'd4
  } sampler_state_t;

endpackage

// File: rtl/cell_voltage_sampler_if.sv
// Start/done handshake between the cell voltage sampler and a single-channel ADC.
interface cell_voltage_sampler_if;
  import bms_pkg::*;

  logic             adc_start;
  logic [CH_W-1:0]  adc_channel;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;

  modport master (output adc_start, adc_channel, input adc_done, adc_data);
  modport slave  (input adc_start, adc_channel, output adc_done, adc_data);

endinterface

// File: rtl/bms_cycle_timer.sv
// Loadable 16-bit up-counter; tc flags the last cycle of a limit-cycle interval.
module bms_cycle_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] limit,
  output logic        tc
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (run) begin
      count <= count + 16'd1;
    end
  end

  assign tc = run && (count == limit - 16'd1);

endmodule

// File: rtl/cell_voltage_sampler.sv
// Periodically scans ADC channels 0..2 into shadow registers and publishes all three
// cell voltages together; a sticky fault flags a scan aborted on ADC timeout.
module cell_voltage_sampler
  import bms_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned ADC_TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  cell_voltage_sampler_if.master adc,
  output logic [ADC_W-1:0]       cell_1_voltage,
  output logic [ADC_W-1:0]       cell_2_voltage,
  output logic [ADC_W-1:0]       cell_3_voltage,
  output logic                   sample_valid,
  output logic                   adc_timeout_fault
);

  sampler_state_t   state, next_state;
  logic [CH_W-1:0]  index, next_index;
  logic [ADC_W-1:0] shadow [NUM_CELLS];
  logic             in_convert, in_wait;
  logic             adc_tc, period_tc;
  logic             capture, abort, publish, start_next;

  assign in_convert = (state == ST_CONVERT);
  assign in_wait    = (state == ST_WAIT_PERIOD);

  bms_cycle_timer u_adc_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (!in_convert),
    .run   (in_convert),
    .limit (16'(ADC_TIMEOUT)),
    .tc    (adc_tc)
  );

  bms_cycle_timer u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (!in_wait),
    .run   (in_wait),
    .limit (16'(SAMPLE_PERIOD)),
    .tc    (period_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      index <= CH_CELL1;
    end else begin
      state <= next_state;
      index <= next_index;
    end
  end

  // Dropping enable overrides every other transition, including done and timeout.
  always_comb begin
    next_state = state;
    next_index = index;
    if (state != ST_IDLE && !enable) begin
      next_state = ST_IDLE;
      next_index = CH_CELL1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            next_state = ST_START;
            next_index = CH_CELL1;
          end
        end
        ST_START: next_state = ST_CONVERT;
        ST_CONVERT: begin
          if (adc.adc_done) begin
            if (index == CH_CELL3) begin
              next_state = ST_PUBLISH;
            end else begin
              next_state = ST_START;
              next_index = index + 2'd1;
            end
          end else if (adc_tc) begin
            next_state = ST_WAIT_PERIOD;
            next_index = CH_CELL1;
          end
        end
        ST_PUBLISH: begin
          next_state = ST_WAIT_PERIOD;
          next_index = CH_CELL1;
        end
        ST_WAIT_PERIOD: begin
          if (period_tc) next_state = ST_START;
        end
        default: begin
          next_state = ST_IDLE;
          next_index = CH_CELL1;
        end
      endcase
    end
  end

  always_comb begin
    capture    = in_convert && enable && adc.adc_done;
    abort      = in_convert && enable && !adc.adc_done && adc_tc;
    publish    = (state == ST_PUBLISH) && enable;
    start_next = (next_state == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc.adc_start     <= 1'b0;
      sample_valid      <= 1'b0;
      adc_timeout_fault <= 1'b0;
      cell_1_voltage    <= '0;
      cell_2_voltage    <= '0;
      cell_3_voltage    <= '0;
    end else begin
      adc.adc_start <= start_next;
      sample_valid  <= publish;
      if (publish) begin
        cell_1_voltage    <= shadow[CH_CELL1];
        cell_2_voltage    <= shadow[CH_CELL2];
        cell_3_voltage    <= shadow[CH_CELL3];
        adc_timeout_fault <= 1'b0;
      end else if (abort) begin
        adc_timeout_fault <= 1'b1;
      end
    end
  end

  // Shadows are only ever published after a full scan rewrites all three.
  always_ff @(posedge clk) begin
    if (capture) shadow[index] <= adc.adc_data;
  end

  assign adc.adc_channel = index;

endmodule

// File: tb/tb_cell_voltage_sampler.sv
// Scoreboard bench for cell_voltage_sampler with a behavioural ADC and timing model.
module tb_cell_voltage_sampler;

  localparam int SP = 20;
  localparam int TO = 8;

  logic        clk, rst, enable;
  logic [11:0] cell_1_voltage, cell_2_voltage, cell_3_voltage;
  logic        sample_valid, adc_timeout_fault;

  cell_voltage_sampler_if adc_bus ();

  cell_voltage_sampler #(.SAMPLE_PERIOD(SP), .ADC_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .adc               (adc_bus),
    .cell_1_voltage    (cell_1_voltage),
    .cell_2_voltage    (cell_2_voltage),
    .cell_3_voltage    (cell_3_voltage),
    .sample_valid      (sample_valid),
    .adc_timeout_fault (adc_timeout_fault)
  );

  // lat = ADC answer cycle within CONVERT (1 = first cycle), 0 = never answers
  typedef struct { int lat; logic [11:0] data; int ch; } conv_t;
  typedef struct { logic [11:0] v1; logic [11:0] v2; logic [11:0] v3; int lat; } pub_t;

  conv_t plan_q[$];
  pub_t  exp_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rst_q = 1'b1;
  bit   en_q = 1'b0;
  int   scan_t0 = -1;
  int   exp_start = -1;
  int   fault_at = -1;
  int   valid_at = -1;
  bit   spur_ok = 1'b0;
  bit   spur_en = 1'b0;
  bit   exp_fault = 1'b0;
  logic [11:0] last1 = '0, last2 = '0, last3 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_q = rst;
      en_q  = enable;
    end
  end

  // ADC responder plus expected start/fault timing derived from scan rules.
  initial begin : adc_model
    conv_t       e;
    int          cd;
    logic [11:0] pend;
    cd = 0;
    pend = '0;
    adc_bus.adc_done = 1'b0;
    adc_bus.adc_data = '0;
    forever begin
      @(negedge clk);
      adc_bus.adc_done = 1'b0;
      if (rst_q || !en_q) begin
        cd = 0; exp_start = -1; fault_at = -1; valid_at = -1; spur_ok = 1'b0;
        if (rst_q) exp_fault = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          adc_bus.adc_done = 1'b1;
          adc_bus.adc_data = pend;
        end
      end else if (spur_en && spur_ok && cyc == exp_start - 10) begin
        adc_bus.adc_done = 1'b1;
        adc_bus.adc_data = 12'($urandom);
      end
      if (cyc == fault_at) exp_fault = 1'b1;
      if (cyc == valid_at) exp_fault = 1'b0;
      if (adc_bus.adc_start === 1'b1) begin
        if (plan_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unplanned_start: got adc_start at cycle %0d, expected none", cyc);
        end else begin
          e = plan_q.pop_front();
          check("adc_channel", 64'(adc_bus.adc_channel), 64'(e.ch));
          if (exp_start >= 0) check("start_time", 64'(cyc), 64'(exp_start));
          if (e.ch == 0) scan_t0 = cyc;
          cd = e.lat;
          pend = e.data;
          if (e.lat == 0) begin
            fault_at = cyc + TO + 1; exp_start = fault_at + SP; spur_ok = 1'b1;
          end else if (e.ch == 2) begin
            valid_at = cyc + e.lat + 2; exp_start = valid_at + SP; spur_ok = 1'b1;
          end else begin
            exp_start = cyc + e.lat + 1; spur_ok = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    pub_t p;
    forever begin
      @(negedge clk);
      #1;
      if (rst_q) begin last1 = '0; last2 = '0; last3 = '0; end
      check("timeout_fault", 64'(adc_timeout_fault), 64'(exp_fault));
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_valid: got sample_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          p = exp_q.pop_front();
          check("cell_1_voltage", 64'(cell_1_voltage), 64'(p.v1));
          check("cell_2_voltage", 64'(cell_2_voltage), 64'(p.v2));
          check("cell_3_voltage", 64'(cell_3_voltage), 64'(p.v3));
          check("scan_latency", 64'(cyc - scan_t0), 64'(p.lat));
          last1 = p.v1; last2 = p.v2; last3 = p.v3;
        end
      end else begin
        check("held_voltages", 64'({cell_1_voltage, cell_2_voltage, cell_3_voltage}),
              64'({last1, last2, last3}));
      end
    end
  end

  task automatic plan_scan(input int l0, input int l1, input int l2,
                           input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2);
    int          lats [3];
    logic [11:0] ds [3];
    conv_t       c;
    pub_t        p;
    lats[0] = l0; lats[1] = l1; lats[2] = l2;
    ds[0] = d0; ds[1] = d1; ds[2] = d2;
    for (int i = 0; i < 3; i++) begin
      c.lat = lats[i]; c.data = ds[i]; c.ch = i;
      plan_q.push_back(c);
      if (lats[i] == 0) return;
    end
    p.v1 = d0; p.v2 = d1; p.v3 = d2;
    p.lat = 7 + (l0 - 1) + (l1 - 1) + (l2 - 1);
    exp_q.push_back(p);
  endtask

  task automatic wait_exp_empty(input string what);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no sample_valid within 400 cycles, expected one", what);
    end
  endtask

  task automatic wait_plan_empty(input string what);
    int n = 0;
    while (plan_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (plan_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got %0d conversions pending after 400 cycles, expected 0", what, plan_q.size());
    end
  endtask

  function automatic logic [11:0] rand_mv();
    case ($urandom_range(0, 7))
      0:       return 12'd0;
      1:       return 12'hFFF;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin : stimulus
    logic [11:0] a, b, c;
    int          n;
    int          l [3];
    int          nv;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_start", 64'(adc_bus.adc_start), 64'd0);
    check("rst_adc_channel", 64'(adc_bus.adc_channel), 64'd0);
    check("rst_sample_valid", 64'(sample_valid), 64'd0);
    check("rst_fault", 64'(adc_timeout_fault), 64'd0);
    check("rst_voltages", 64'({cell_1_voltage, cell_2_voltage, cell_3_voltage}), 64'd0);
    rst = 1'b0;

    // nominal scan
    plan_scan(2, 2, 2, 12'd3700, 12'd3650, 12'd3900);
    enable = 1'b1;
    wait_exp_empty("nominal_scan");

    // channel 1 never answers
    plan_scan(2, 0, 0, 12'd1111, 12'd0, 12'd0);
    wait_plan_empty("timeout_plan");
    n = 0;
    while (adc_timeout_fault !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("fault_set", 64'(adc_timeout_fault), 64'd1);
    check("abort_no_valid", 64'(sample_valid), 64'd0);
    check("abort_retained", 64'({cell_1_voltage, cell_2_voltage, cell_3_voltage}),
          64'({12'd3700, 12'd3650, 12'd3900}));
    plan_scan(2, 2, 2, 12'd3000, 12'd3000, 12'd3000);
    wait_exp_empty("recovery_scan");
    check("fault_cleared", 64'(adc_timeout_fault), 64'd0);

    // done on the last allowed CONVERT cycle
    a = rand_mv(); b = rand_mv(); c = rand_mv();
    plan_scan(TO, TO, TO, a, b, c);
    wait_exp_empty("collision_scan");
    check("collision_no_fault", 64'(adc_timeout_fault), 64'd0);

    // enable drop during channel 2 conversion
    plan_scan(1, 1, 0, rand_mv(), rand_mv(), 12'd0);
    wait_plan_empty("enable_drop_plan");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("drop_adc_start", 64'(adc_bus.adc_start), 64'd0);
    check("drop_no_valid", 64'(sample_valid), 64'd0);
    check("drop_held", 64'({cell_1_voltage, cell_2_voltage, cell_3_voltage}), 64'({a, b, c}));
    repeat (30) @(negedge clk);
    plan_scan(1, 3, 5, rand_mv(), rand_mv(), rand_mv());
    enable = 1'b1;
    wait_exp_empty("reenable_scan");

    // spurious done in WAIT_PERIOD, then reset in CONVERT with fault set
    spur_en = 1'b1;
    plan_scan(0, 0, 0, 12'd0, 12'd0, 12'd0);
    wait_plan_empty("fault_before_reset");
    plan_scan(1, 0, 0, rand_mv(), 12'd0, 12'd0);
    wait_plan_empty("reset_plan");
    repeat (3) @(negedge clk);
    check("pre_reset_fault", 64'(adc_timeout_fault), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midscan_rst_start", 64'(adc_bus.adc_start), 64'd0);
    check("midscan_rst_channel", 64'(adc_bus.adc_channel), 64'd0);
    check("midscan_rst_fault", 64'(adc_timeout_fault), 64'd0);
    check("midscan_rst_voltages", 64'({cell_1_voltage, cell_2_voltage, cell_3_voltage}), 64'd0);
    plan_scan(2, 1, 4, rand_mv(), rand_mv(), rand_mv());
    rst = 1'b0;
    wait_exp_empty("post_reset_scan");

    // randomized scans, some with a silent channel
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 3; i++) l[i] = $urandom_range(1, TO);
      nv = $urandom_range(0, 4);
      if (nv < 3) l[nv] = 0;
      plan_scan(l[0], l[1], l[2], rand_mv(), rand_mv(), rand_mv());
      if (nv < 3) wait_plan_empty("random_abort");
      else        wait_exp_empty("random_scan");
    end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("plan_queue_drained", 64'(plan_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation time limit at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
